// File: rtl/sw_query_dispatcher.sv
// -----------------------------------------------------------------------------
// sw_query_dispatcher
//
// Command front-end of the Smith-Waterman accelerator. Takes a 128-bit header
// from the host stream and then one 128-bit query word per query. For each
// query it starts the SW core against the DDR3 reference, returns one result
// word per reported hit and then a terminator word.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s1i_*             input stream (valid/rdy/data): header, then query words
//   s1o_*             output stream (valid/rdy/data): result and terminator words
//   core_start        one-cycle start pulse to the SW core
//   core_query        query bases, held from start until the next query is loaded
//   core_ref_base     DDR3 byte address of the first reference block
//   core_ref_blocks   reference length in 256-bit blocks
//   core_threshold    minimum score for a reported hit
//   core_hit_*        hit handshake from the core (valid/ready/loc/score)
//   core_done         core finished the current query (after its last hit)
//   busy              high whenever the dispatcher is not idle
//
// Header word : [31:0] ref_blocks, [63:32] ref_base, [95:64] num_queries,
//               [127:96] threshold (low SCORE_W bits used)
// Result word : [31:0] location, [47:32] query idx, [63:48] score,
//               [126:64] zero, [127] last
// Terminator  : location all-ones, score 0, last = 1
// -----------------------------------------------------------------------------
module sw_query_dispatcher #(
   parameter int DATA_W  = 128,
   parameter int ADDR_W  = 32,
   parameter int IDX_W   = 16,
   parameter int SCORE_W = 16
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               s1i_valid,
   output logic               s1i_rdy,
   input  logic [DATA_W-1:0]  s1i_data,

   output logic               s1o_valid,
   input  logic               s1o_rdy,
   output logic [DATA_W-1:0]  s1o_data,

   output logic               core_start,
   output logic [DATA_W-1:0]  core_query,
   output logic [ADDR_W-1:0]  core_ref_base,
   output logic [31:0]        core_ref_blocks,
   output logic [SCORE_W-1:0] core_threshold,
   input  logic               core_hit_valid,
   output logic               core_hit_ready,
   input  logic [ADDR_W-1:0]  core_hit_loc,
   input  logic [SCORE_W-1:0] core_hit_score,
   input  logic               core_done,

   output logic               busy
);

   // Header field positions
   localparam int HDR_BLOCKS_LSB = 0;
   localparam int HDR_BASE_LSB   = 32;
   localparam int HDR_NUMQ_LSB   = 64;
   localparam int HDR_THR_LSB    = 96;

   // Result word field positions
   localparam int RES_LOC_LSB    = 0;
   localparam int RES_IDX_LSB    = 32;
   localparam int RES_SCORE_LSB  = 48;

   // FSM encoding
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_QLOAD = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_TERM  = 3'd4;
   localparam logic [2:0] S_NEXT  = 3'd5;

   logic [2:0]  state;
   logic [2:0]  state_nxt;

   logic [31:0] num_queries;
   logic [31:0] q_count;      // queries completed since the header
   logic [31:0] q_count_inc;
   logic        done_seen;    // core_done seen for the running query

   logic        in_acc;
   logic        out_free;
   logic        out_pop;
   logic        hit_acc;
   logic        load_hit;
   logic        load_term;
   logic [31:0] hdr_num_queries;

   // --------------------------------------------------------------------------
   // Result word formatting
   // --------------------------------------------------------------------------
   function automatic logic [DATA_W-1:0] result_word(
      input logic [ADDR_W-1:0]  loc,
      input logic [IDX_W-1:0]   idx,
      input logic [SCORE_W-1:0] score,
      input logic               last
   );
      logic [DATA_W-1:0] w;
      w = '0;
      w[RES_LOC_LSB   +: ADDR_W]  = loc;
      w[RES_IDX_LSB   +: IDX_W]   = idx;
      w[RES_SCORE_LSB +: SCORE_W] = score;
      w[DATA_W-1]                 = last;
      return w;
   endfunction

   // --------------------------------------------------------------------------
   // Handshakes and combinational outputs
   // --------------------------------------------------------------------------
   // s1i_rdy is also held low during reset so every output reads 0 while rst
   // is asserted, even though the state register is already IDLE.
   assign s1i_rdy        = !rst && ((state == S_IDLE) || (state == S_QLOAD));
   assign in_acc         = s1i_valid && s1i_rdy;

   // Single-entry output register: it can accept a new word in the same cycle
   // the held word is taken downstream.
   assign out_free       = !s1o_valid || s1o_rdy;
   assign out_pop        = s1o_valid && s1o_rdy;

   assign core_hit_ready = (state == S_RUN) && out_free;
   assign hit_acc        = core_hit_valid && core_hit_ready;

   assign load_hit       = hit_acc;
   assign load_term      = (state == S_TERM) && out_free;

   assign core_start     = (state == S_START);
   assign busy           = (state != S_IDLE);

   assign q_count_inc     = q_count + 32'd1;
   assign hdr_num_queries = s1i_data[HDR_NUMQ_LSB +: 32];

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            // A header with zero queries is consumed and the block stays idle.
            if (in_acc && (hdr_num_queries != '0)) begin
               state_nxt = S_QLOAD;
            end
         end
         S_QLOAD: begin
            if (in_acc) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            // A hit still offered by the core must be taken before the
            // terminator, so a hit arriving with done is emitted first.
            if (done_seen && !core_hit_valid) begin
               state_nxt = S_TERM;
            end
         end
         S_TERM: begin
            if (out_free) begin
               state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (out_pop) begin
               state_nxt = (q_count_inc == num_queries) ? S_IDLE : S_QLOAD;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State, header and query registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         core_ref_blocks <= '0;
         core_ref_base   <= '0;
         num_queries     <= '0;
         core_threshold  <= '0;
         core_query      <= '0;
         q_count         <= '0;
         done_seen       <= 1'b0;
      end else begin
         state <= state_nxt;

         if ((state == S_IDLE) && in_acc) begin
            core_ref_blocks <= s1i_data[HDR_BLOCKS_LSB +: 32];
            core_ref_base   <= s1i_data[HDR_BASE_LSB   +: ADDR_W];
            num_queries     <= hdr_num_queries;
            core_threshold  <= s1i_data[HDR_THR_LSB    +: SCORE_W];
            q_count         <= '0;
         end

         if ((state == S_QLOAD) && in_acc) begin
            core_query <= s1i_data;
         end

         if (state == S_START) begin
            done_seen <= 1'b0;
         end else if ((state == S_RUN) && core_done) begin
            done_seen <= 1'b1;
         end

         if ((state == S_NEXT) && out_pop) begin
            q_count <= q_count_inc;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s1o_valid <= 1'b0;
         s1o_data  <= '0;
      end else begin
         if (load_hit) begin
            s1o_valid <= 1'b1;
            s1o_data  <= result_word(core_hit_loc, q_count[IDX_W-1:0],
                                     core_hit_score, 1'b0);
         end else if (load_term) begin
            s1o_valid <= 1'b1;
            s1o_data  <= result_word('1, q_count[IDX_W-1:0], '0, 1'b1);
         end else if (out_pop) begin
            s1o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sw_query_dispatcher.sv
module tb_sw_query_dispatcher;

   logic         clk = 1'b0;
   logic         rst;
   logic         s1i_valid;
   logic         s1i_rdy;
   logic [127:0] s1i_data;
   logic         s1o_valid;
   logic         s1o_rdy;
   logic [127:0] s1o_data;
   logic         core_start;
   logic [127:0] core_query;
   logic [31:0]  core_ref_base;
   logic [31:0]  core_ref_blocks;
   logic [15:0]  core_threshold;
   logic         core_hit_valid;
   logic         core_hit_ready;
   logic [31:0]  core_hit_loc;
   logic [15:0]  core_hit_score;
   logic         core_done;
   logic         busy;

   always #5 clk = ~clk;

   sw_query_dispatcher #(
      .DATA_W  (128),
      .ADDR_W  (32),
      .IDX_W   (16),
      .SCORE_W (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s1i_valid       (s1i_valid),
      .s1i_rdy         (s1i_rdy),
      .s1i_data        (s1i_data),
      .s1o_valid       (s1o_valid),
      .s1o_rdy         (s1o_rdy),
      .s1o_data        (s1o_data),
      .core_start      (core_start),
      .core_query      (core_query),
      .core_ref_base   (core_ref_base),
      .core_ref_blocks (core_ref_blocks),
      .core_threshold  (core_threshold),
      .core_hit_valid  (core_hit_valid),
      .core_hit_ready  (core_hit_ready),
      .core_hit_loc    (core_hit_loc),
      .core_hit_score  (core_hit_score),
      .core_done       (core_done),
      .busy            (busy)
   );

   // Scoreboard of expected output words, in order
   logic [127:0] exp_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int start_cnt   = 0;

   bit in_acc;
   bit hit_acc;
   bit stall_acc;

   logic [127:0] exp_query;
   logic [31:0]  exp_base;
   logic [31:0]  exp_blocks;
   logic [15:0]  exp_thr;
   logic [15:0]  exp_idx;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [31:0] loc, input logic [15:0] idx,
                                       input logic [15:0] score, input logic last);
      mk = {last, 63'd0, score, idx, loc};
   endfunction

   // One clock cycle: sample handshakes at the falling edge, check any output
   // word against the scoreboard, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      in_acc  = s1i_valid && s1i_rdy;
      hit_acc = core_hit_valid && core_hit_ready;
      if (!rst && s1o_valid && s1o_rdy) begin
         if (exp_q.size() != 0) chk("out_word", s1o_data, exp_q.pop_front());
         else                   chk("out_unexpected", s1o_valid, 1'b0);
      end
      if (core_start) begin
         start_cnt++;
         chk("start_base",   core_ref_base,   exp_base);
         chk("start_blocks", core_ref_blocks, exp_blocks);
         chk("start_thr",    core_threshold,  exp_thr);
         chk("start_query",  core_query,      exp_query);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [127:0] d, input string tag);
      s1i_valid = 1'b1;
      s1i_data  = d;
      in_acc    = 1'b0;
      for (int i = 0; i < 50 && !in_acc; i++) tick();
      s1i_valid = 1'b0;
      chk({tag, "_accept"}, in_acc, 1'b1);
   endtask

   task automatic send_header(input logic [31:0] blocks, input logic [31:0] base,
                              input logic [31:0] nq, input logic [15:0] thr);
      exp_blocks = blocks;
      exp_base   = base;
      exp_thr    = thr;
      exp_idx    = '0;
      send_word({16'h0000, thr, nq, base, blocks}, "header");
   endtask

   task automatic start_query(input logic [127:0] q);
      exp_query = q;
      send_word(q, "query");
      chk("start_timing", core_start, 1'b1);
      tick();
      chk("start_width", core_start, 1'b0);
   endtask

   task automatic send_hit(input logic [31:0] loc, input logic [15:0] score);
      core_hit_valid = 1'b1;
      core_hit_loc   = loc;
      core_hit_score = score;
      hit_acc        = 1'b0;
      for (int i = 0; i < 100 && !hit_acc; i++) tick();
      core_hit_valid = 1'b0;
      chk("hit_accept", hit_acc, 1'b1);
      exp_q.push_back(mk(loc, exp_idx, score, 1'b0));
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic finish_query();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      exp_q.push_back(mk(32'hFFFF_FFFF, exp_idx, 16'h0000, 1'b1));
      drain();
      exp_idx++;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s1i_rdy"},    s1i_rdy,         1'b0);
      chk({tag, "_s1o_valid"},  s1o_valid,       1'b0);
      chk({tag, "_s1o_data"},   s1o_data,        128'd0);
      chk({tag, "_core_start"}, core_start,      1'b0);
      chk({tag, "_query"},      core_query,      128'd0);
      chk({tag, "_base"},       core_ref_base,   32'd0);
      chk({tag, "_blocks"},     core_ref_blocks, 32'd0);
      chk({tag, "_thr"},        core_threshold,  16'd0);
      chk({tag, "_hit_ready"},  core_hit_ready,  1'b0);
      chk({tag, "_busy"},       busy,            1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] q;
      rst            = 1'b1;
      s1i_valid      = 1'b0;
      s1i_data       = '0;
      s1o_rdy        = 1'b1;
      core_hit_valid = 1'b0;
      core_hit_loc   = '0;
      core_hit_score = '0;
      core_done      = 1'b0;
      exp_query      = '0;
      exp_base       = '0;
      exp_blocks     = '0;
      exp_thr        = '0;
      exp_idx        = '0;

      // Reset state
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();
      chk("idle_s1i_rdy", s1i_rdy, 1'b1);
      chk("idle_busy", busy, 1'b0);
      // Hits offered outside RUN are not accepted
      core_hit_valid = 1'b1;
      core_hit_loc   = 32'h1234;
      tick();
      chk("idle_hit_ready", core_hit_ready, 1'b0);
      chk("idle_no_output", s1o_valid, 1'b0);
      core_hit_valid = 1'b0;

      // 1) Single query with one hit
      exp_blocks = 32'd8;
      exp_base   = 32'd0;
      exp_thr    = 16'h0080;
      exp_idx    = '0;
      send_word(128'h00000080_00000001_00000000_00000008, "t1_header");
      chk("t1_busy", busy, 1'b1);
      chk("t1_qload_rdy", s1i_rdy, 1'b1);
      start_query(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      chk("t1_run_rdy", s1i_rdy, 1'b0);
      send_hit(32'h80, 16'h0090);
      finish_query();
      chk("t1_idle", busy, 1'b0);
      chk("t1_starts", start_cnt, 1);

      // 2) Three queries with no hits
      start_cnt = 0;
      send_header(32'd16, 32'h0000_1000, 32'd3, 16'h0020);
      for (int n = 0; n < 3; n++) begin
         q = {$urandom(), $urandom(), $urandom(), $urandom()};
         start_query(q);
         finish_query();
      end
      chk("t2_starts", start_cnt, 3);
      chk("t2_idle", busy, 1'b0);

      // 3) Output backpressure during four hits
      send_header(32'd4, 32'h0000_2000, 32'd1, 16'h0010);
      start_query(128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555);
      s1o_rdy = 1'b0;
      send_hit(32'd100, 16'd1);
      core_hit_valid = 1'b1;
      core_hit_loc   = 32'd200;
      core_hit_score = 16'd2;
      stall_acc      = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         stall_acc = stall_acc | hit_acc;
      end
      chk("t3_stall_no_accept", stall_acc, 1'b0);
      chk("t3_stall_ready", core_hit_ready, 1'b0);
      chk("t3_held_valid", s1o_valid, 1'b1);
      chk("t3_held_data", s1o_data, mk(32'd100, exp_idx, 16'd1, 1'b0));
      s1o_rdy = 1'b1;
      send_hit(32'd200, 16'd2);
      send_hit(32'd300, 16'd3);
      send_hit(32'd400, 16'd4);
      finish_query();
      chk("t3_idle", busy, 1'b0);

      // 4) Hit and done in the same cycle
      send_header(32'd2, 32'h0000_3000, 32'd1, 16'h0005);
      start_query(128'h1111_2222_3333_4444_5555_6666_7777_8888);
      core_hit_valid = 1'b1;
      core_hit_loc   = 32'd5;
      core_hit_score = 16'd7;
      core_done      = 1'b1;
      tick();
      core_hit_valid = 1'b0;
      core_done      = 1'b0;
      chk("t4_hit_accept", hit_acc, 1'b1);
      exp_q.push_back(mk(32'd5, exp_idx, 16'd7, 1'b0));
      exp_q.push_back(mk(32'hFFFF_FFFF, exp_idx, 16'h0000, 1'b1));
      drain();
      chk("t4_idle", busy, 1'b0);

      // 5) Header with zero queries
      send_header(32'd1, 32'h0000_4000, 32'd0, 16'h0001);
      chk("t5_busy", busy, 1'b0);
      chk("t5_rdy", s1i_rdy, 1'b1);
      repeat (5) tick();
      chk("t5_no_output", s1o_valid, 1'b0);

      // 6) Reset while running with a word held in the output register
      send_header(32'd9, 32'h0000_5000, 32'd2, 16'h0033);
      start_query(128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
      s1o_rdy = 1'b0;
      send_hit(32'h55, 16'h0009);
      chk("t6_held_valid", s1o_valid, 1'b1);
      rst = 1'b1;
      tick();
      chk_all_zero("t6_reset");
      exp_q.delete();
      rst     = 1'b0;
      s1o_rdy = 1'b1;
      tick();
      chk("t6_no_output", s1o_valid, 1'b0);
      send_header(32'd3, 32'h0000_6000, 32'd1, 16'h0044);
      start_query(128'h0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0);
      send_hit(32'h66, 16'h0011);
      finish_query();
      chk("t6_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
